// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, result-width function and BCD digit constants.
// Imported by the interface, the digit-adjust cell and the top.
package bcd_pkg;

   // Converter control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Largest legal BCD digit, and the reverse double-dabble correction
   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_VAL    = 4'd3;

   // Iteration counter width; covers up to 14 iterations
   localparam int CNT_W = 4;

   // Binary width needed to hold 10^n - 1 exactly
   function automatic int bin_w(input int n_digits);
      case (n_digits)
         1:       return 4;
         2:       return 7;
         3:       return 10;
         default: return 14;
      endcase
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle between a requester and the BCD-to-binary converter.
// Master drives start/bcd_in; slave returns busy/done/bin_out/error.
// Result width follows the digit count through the package width function.
interface bcd_to_bin_seq_if #(
   parameter int N_DIGITS = 4
);
   import bcd_pkg::*;

   localparam int BIN_W = bin_w(N_DIGITS);

   logic                    start;
   logic [4*N_DIGITS-1:0]   bcd_in;
   logic                    busy;
   logic                    done;
   logic [BIN_W-1:0]        bin_out;
   logic                    error;

   modport master (
      output start,
      output bcd_in,
      input  busy,
      input  done,
      input  bin_out,
      input  error
   );

   modport slave (
      input  start,
      input  bcd_in,
      output busy,
      output done,
      output bin_out,
      output error
   );

endinterface

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// Purpose: one BCD digit's reverse double-dabble correction (subtract 3 if >= 8).
// Latency: purely combinational, zero cycles.
// Backpressure: none; always accepts its input.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   // After a right shift a digit >= 8 carried in a 1 worth 5, not 8: take 3 off
   always_comb begin
      digit_out = digit_in;
      if (digit_in >= ADJ_THRESH) begin
         digit_out = digit_in - ADJ_VAL;
      end
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Purpose: sequential BCD-to-binary converter (reverse double-dabble); optional digit check via BCD2BIN_DIGIT_CHECK_EN.
// Latency: done rises BIN_W edges after the accepting edge (BIN_W+1 counting it); 1 edge after it on a bad digit.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   bcd_to_bin_seq_if.slave   bus
);

   localparam int BIN_W = bin_w(N_DIGITS);
   localparam int BCD_W = 4 * N_DIGITS;

   state_t                  state_q, state_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [BIN_W-1:0]        bin_q, bin_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BIN_W-1:0]        bin_out_q, bin_out_d;

   logic [BCD_W+BIN_W-1:0]  shift_all;
   logic [BCD_W-1:0]        bcd_shift;
   logic [BCD_W-1:0]        bcd_adj;
   logic [BIN_W-1:0]        bin_shift;

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic                    bad_q, bad_d;
   logic                    error_q, error_d;
   logic                    bad_in;
`endif

   // One combined right shift of {bcd, bin}: the BCD LSB falls into the binary MSB
   assign shift_all = {bcd_q, bin_q} >> 1;
   assign bcd_shift = shift_all[BCD_W+BIN_W-1:BIN_W];
   assign bin_shift = shift_all[BIN_W-1:0];

   // Per-digit correction applied to the shifted BCD register
   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_in  (bcd_shift[4*g +: 4]),
         .digit_out (bcd_adj[4*g +: 4])
      );
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   // Flag any digit above 9 on the incoming request
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bus.bcd_in[4*i +: 4] > BCD_MAX) begin
            bad_in = 1'b1;
         end
      end
   end
`endif

   // Next-state and datapath: accept in IDLE, iterate in SHIFT, present in DONE
   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      cnt_d     = cnt_q;
      bin_out_d = bin_out_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad_d     = bad_q;
      error_d   = error_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_SHIFT;
               bcd_d   = bus.bcd_in;
               bin_d   = '0;
               cnt_d   = '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
               bad_d   = bad_in;
`endif
            end
         end
         ST_SHIFT: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (bad_q) begin
               // Invalid request: report it without spending the iterations
               state_d   = ST_DONE;
               bin_out_d = '0;
               error_d   = 1'b1;
            end else
`endif
            begin
               bcd_d = bcd_adj;
               bin_d = bin_shift;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BIN_W - 1)) begin
                  // Last iteration: the shifted binary word is the final result
                  state_d   = ST_DONE;
                  bin_out_d = bin_shift;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  error_d   = 1'b0;
`endif
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         bin_out_q <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         bad_q     <= 1'b0;
         error_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         cnt_q     <= cnt_d;
         bin_out_q <= bin_out_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         bad_q     <= bad_d;
         error_q   <= error_d;
`endif
      end
   end

   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.bin_out = bin_out_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
   assign bus.error   = error_q;
`else
   assign bus.error   = 1'b0;
`endif

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
- REQ-001 The block SHALL have parameter N_DIGITS, default 4, giving the number of BCD input digits; legal values are 1 to 4.
- REQ-002 The block SHALL derive BIN_W (4, 7, 10, 14 for N_DIGITS 1 to 4) from a package function.
- REQ-003 The clock and reset SHALL be: one clock; reset is asynchronous and active-high.
- REQ-004 Port clk, input, 1 bit: rising-edge clock.
- REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
- REQ-006 Port start, input, 1 bit: conversion request, sampled only in IDLE.
- REQ-007 Port bcd_in, input, 4*N_DIGITS bits: BCD digits, least significant digit in [3:0].
- REQ-008 Port busy, output, 1 bit: high while not in IDLE.
- REQ-009 Port done, output, 1 bit: one-cycle pulse when the result is valid.
- REQ-010 Port bin_out, output, BIN_W bits: registered binary result, held until the next accepted start.
- REQ-011 Port error, output, 1 bit: invalid-digit flag, updated together with done.

Function
- REQ-012 Conversion SHALL use the reverse double-dabble algorithm: shift right {bcd_reg, bin_reg}, then subtract 3 from every BCD digit that is >= 8.
- REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
- REQ-014 IDLE to SHIFT: on the edge where start=1, bcd_in is latched, bin_reg is cleared and the iteration counter is set to 0.
- REQ-015 SHIFT SHALL perform one iteration per cycle for exactly BIN_W cycles, then go to DONE.
- REQ-016 DONE SHALL last one cycle, with done=1 and bin_out/error valid, then return to IDLE.
- REQ-017 Latency: done SHALL rise BIN_W+1 cycles after the start-sampling edge; for N_DIGITS=4 this is 15 cycles.
- REQ-018 start SHALL be ignored while busy=1; start held high SHALL be accepted again in the first IDLE cycle after DONE.
- REQ-019 bcd_in SHALL be sampled only at acceptance; later changes have no effect on the running conversion.
- REQ-020 The result SHALL be exact for all valid inputs 0 to 10^N_DIGITS-1, with no overflow possible.

Reset
- REQ-021 When rst asserts, the block SHALL go to IDLE immediately, regardless of clock.
- REQ-022 During reset, busy=0, done=0, error=0, bin_out=0 and all internal registers SHALL be 0.
- REQ-023 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
- REQ-024 With macro BCD2BIN_DIGIT_CHECK_EN defined, a digit > 9 at acceptance SHALL skip SHIFT and go directly to DONE on the next edge, with error=1 and bin_out=0.
- REQ-025 Without BCD2BIN_DIGIT_CHECK_EN, error SHALL be tied to 0 and invalid digits SHALL run the normal algorithm, giving an unspecified but deterministic bin_out.

Structure
- REQ-026 A shared package bcd_pkg SHALL hold the FSM state enumeration, the BIN_W width function and the digit constants (BCD_MAX=9, ADJ_THRESH=8, ADJ_VAL=3).
- REQ-027 One sub-module, bcd_digit_adjust, SHALL hold the per-digit conditional subtract-3; it is instantiated N_DIGITS times.

Verification
- REQ-028 Test 1: bcd_in=16'h1234 with a one-cycle start -> busy=1 for 15 cycles, then done for one cycle with bin_out=14'd1234 and error=0.
- REQ-029 Test 2: bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F); bcd_in=16'h0000 -> bin_out=0, done after 15 cycles.
- REQ-030 Test 3: start pulsed again at cycle 5 of a conversion, with a different bcd_in -> ignored; the result is the first input and exactly one done pulse occurs.
- REQ-031 Test 4: rst pulsed at cycle 7 of a conversion -> outputs zero at once, no done pulse; the next start with 16'h0042 gives 14'd42.
- REQ-032 Test 5 (macro defined): bcd_in=16'h12A4 -> done two edges after start, with error=1 and bin_out=0; the macro-undefined build gives error=0 with done at 15 cycles.
- REQ-033 Test 6: start held high continuously with bcd_in=16'h0500 -> back-to-back conversions, each done spaced 16 cycles apart, each with bin_out=14'd500.
